uart_tx_frame_ctrl: RTL and testbench

UART transmit framer. It sits directly downstream of the parity calculator in the TX path. It accepts a parallel data word with a valid strobe and serialises one frame on tx_out: start bit, data LSB-first, optional parity bit, stop bit. The parity bit comes from the parity calculator's registered output (par_bit_in). clk is the already-divided TX bit clock, so one bit is sent per clk cycle.

---
 rtl/uart_tx_frame_ctrl.sv | 115 +++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit framer: start, LSB-first data, optional parity, stop
module uart_tx_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] p_data_in,
    input  logic             data_valid_in,
    input  logic             par_en_in,
    input  logic             par_bit_in,
    output logic             tx_out,
    output logic             busy_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             par_en_q, par_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc  = cnt_q + 1'b1;
    assign tx_out   = tx_q;
    assign busy_out = busy_q;

    // Next-state logic; line and busy are computed from the state being entered
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        par_en_d = par_en_q;
        cnt_d    = cnt_q;
        tx_d     = 1'b1;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_valid_in) begin
                    state_d  = START;
                    shadow_d = p_data_in;
                    par_en_d = par_en_in;
                    cnt_d    = '0;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = shadow_q[0];
                busy_d  = 1'b1;
            end
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds at the last index so it never wraps
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_in;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    tx_d  = shadow_q[cnt_inc];
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
                busy_d  = 1'b1;
            end
            STOP: begin
                // Always passes through IDLE, giving one idle-high bit between frames
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            par_en_q <= 1'b0;
            cnt_q    <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            par_en_q <= par_en_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - self-checking bench for uart_tx_frame_ctrl
module tb_uart_tx_frame_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] p_data_in = '0;
    logic         data_valid_in = 1'b0;
    logic         par_en_in = 1'b0;
    logic         par_bit_in = 1'b0;
    logic         tx_out;
    logic         busy_out;

    int checks = 0;
    int failures = 0;
    logic exp_q[$];

    // Free-running bit clock
    always #5 clk = ~clk;

    uart_tx_frame_ctrl #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .p_data_in     (p_data_in),
        .data_valid_in (data_valid_in),
        .par_en_in     (par_en_in),
        .par_bit_in    (par_bit_in),
        .tx_out        (tx_out),
        .busy_out      (busy_out)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line sequence of one frame
    task automatic build(input logic [W-1:0] d, input logic pe, input logic pb);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int j = 0; j < W; j++) exp_q.push_back(d[j]);
        if (pe) exp_q.push_back(pb);
        exp_q.push_back(1'b1);
    endtask

    // Called right after the accept edge; checks every bit plus the idle bit after it.
    // mode 1: valid pulses with FF in DATA and STOP; mode 2: scramble data/par_en each bit
    task automatic check_frame(input string tag, input int mode, input logic hold);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s_tx%0d", tag, i), W'(tx_out), W'(exp_q[i]));
            chk($sformatf("%s_busy%0d", tag, i), W'(busy_out), W'(1));
            if (i == 0 && !hold) data_valid_in = 1'b0;
            if (mode == 1) begin
                if (i == 3) begin data_valid_in = 1'b1; p_data_in = '1; end
                if (i == 4) data_valid_in = 1'b0;
                if (i == n - 1) begin data_valid_in = 1'b1; p_data_in = '1; end
            end
            if (mode == 2) begin
                p_data_in = W'($urandom);
                par_en_in = 1'($urandom);
            end
        end
        @(negedge clk);
        chk({tag, "_idle_tx"}, W'(tx_out), W'(1));
        chk({tag, "_idle_busy"}, W'(busy_out), W'(0));
        if (mode == 1) data_valid_in = 1'b0;
    endtask

    task automatic check_idle(input string tag, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            chk({tag, "_tx"}, W'(tx_out), W'(1));
            chk({tag, "_busy"}, W'(busy_out), W'(0));
        end
    endtask

    task automatic launch(input logic [W-1:0] d, input logic pe, input logic pb);
        p_data_in = d;
        par_en_in = pe;
        par_bit_in = pb;
        data_valid_in = 1'b1;
        build(d, pe, pb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic rpe, rpb;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tx", W'(tx_out), W'(1));
        chk("rst_busy", W'(busy_out), W'(0));
        reset_n = 1'b1;
        check_idle("post_rst", 2);

        // Reset mid-DATA aborts asynchronously
        @(negedge clk);
        launch(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        data_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before_rst", W'(busy_out), W'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tx", W'(tx_out), W'(1));
        chk("async_rst_busy", W'(busy_out), W'(0));
        @(negedge clk);
        reset_n = 1'b1;
        check_idle("after_abort", 3);

        // Parity frame A5
        launch(8'hA5, 1'b1, 1'b0);
        check_frame("par_a5", 0, 1'b0);

        // No-parity frame 0F with par_bit forced high
        launch(8'h0F, 1'b0, 1'b1);
        check_frame("nopar_0f", 0, 1'b0);
        check_idle("nopar_after", 1);

        // Valid ignored while busy
        launch(8'h3C, 1'b1, 1'b1);
        check_frame("busy_3c", 1, 1'b0);
        check_idle("busy_after", 3);

        // Back-to-back with valid held
        launch(8'h55, 1'b1, 1'b1);
        p_data_in = 8'hAA;
        check_frame("b2b_55", 0, 1'b1);
        par_bit_in = 1'b0;
        build(8'hAA, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        data_valid_in = 1'b0;
        check_frame("b2b_aa", 0, 1'b1);
        check_idle("b2b_after", 2);

        // Inputs scrambled after acceptance
        launch(8'h81, 1'b1, 1'b1);
        check_frame("latch_81", 2, 1'b0);
        par_en_in = 1'b0;
        check_idle("latch_after", 1);

        // Randomized frames with random gaps
        for (int k = 0; k < 16; k++) begin
            rd = W'($urandom);
            rpe = 1'($urandom);
            rpb = 1'($urandom);
            launch(rd, rpe, rpb);
            check_frame($sformatf("rnd%0d", k), 0, 1'b0);
            check_idle($sformatf("rnd%0d_gap", k), $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
